msg_schedule_stream: RTL and testbench

Parametrised streaming SHA-2 message-schedule generator. Accepts one 16-word padded block over a valid/ready input stream and emits W0..W(ROUNDS-1) one word per cycle on a valid/ready output stream. It keeps a rolling 16-word window instead of a full ROUNDS-deep array. It sits between the block padder and the compression round core.

---
 rtl/msg_sched_pkg.sv | 52 +++++
 rtl/msg_sched_sigma.sv | 28 ++
 rtl/msg_schedule_stream.sv | 157 +++++++++++++++
 tb/tb_msg_schedule_stream.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_sched_pkg.sv
// Shared types and sigma functions for the SHA-2 message-schedule stream.
package msg_sched_pkg;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    // Depth of the rolling window: the recurrence reaches back to W(t-16).
    localparam int WIN_DEPTH = 16;

    // SHA-256 (32-bit word) rotation/shift amounts.
    localparam int S256_S0_R1 = 7;
    localparam int S256_S0_R2 = 18;
    localparam int S256_S0_SH = 3;
    localparam int S256_S1_R1 = 17;
    localparam int S256_S1_R2 = 19;
    localparam int S256_S1_SH = 10;

    // SHA-512 (64-bit word) rotation/shift amounts.
    localparam int S512_S0_R1 = 1;
    localparam int S512_S0_R2 = 8;
    localparam int S512_S0_SH = 7;
    localparam int S512_S1_R1 = 19;
    localparam int S512_S1_R2 = 61;
    localparam int S512_S1_SH = 6;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] sigma0_32(input logic [31:0] x);
        return rotr32(x, S256_S0_R1) ^ rotr32(x, S256_S0_R2) ^ (x >> S256_S0_SH);
    endfunction

    function automatic logic [31:0] sigma1_32(input logic [31:0] x);
        return rotr32(x, S256_S1_R1) ^ rotr32(x, S256_S1_R2) ^ (x >> S256_S1_SH);
    endfunction

    function automatic logic [63:0] sigma0_64(input logic [63:0] x);
        return rotr64(x, S512_S0_R1) ^ rotr64(x, S512_S0_R2) ^ (x >> S512_S0_SH);
    endfunction

    function automatic logic [63:0] sigma1_64(input logic [63:0] x);
        return rotr64(x, S512_S1_R1) ^ rotr64(x, S512_S1_R2) ^ (x >> S512_S1_SH);
    endfunction

endpackage

// File: rtl/msg_sched_sigma.sv
// Combinational small-sigma pair (s0, s1) for the selected SHA-2 word width.
module msg_sched_sigma
    import msg_sched_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] s0_in,
    input  logic [WORD_W-1:0] s1_in,
    output logic [WORD_W-1:0] s0_out,
    output logic [WORD_W-1:0] s1_out
);

    // Pick the sigma set at elaboration time; only 32 and 64 are legal widths.
    generate
        if (WORD_W == 32) begin : g_sha256
            assign s0_out = sigma0_32(s0_in);
            assign s1_out = sigma1_32(s1_in);
        end else if (WORD_W == 64) begin : g_sha512
            assign s0_out = sigma0_64(s0_in);
            assign s1_out = sigma1_64(s1_in);
        end else begin : g_bad_width
            $error("msg_sched_sigma: WORD_W must be 32 or 64");
            assign s0_out = '0;
            assign s1_out = '0;
        end
    endgenerate

endmodule

// File: rtl/msg_schedule_stream.sv
// Streaming SHA-2 message-schedule generator: loads W0..W15 from the input
// stream, then expands W16..W(ROUNDS-1) from a rolling 16-word window.
module msg_schedule_stream
    import msg_sched_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    generate
        if (ROUNDS <= WIN_DEPTH) begin : g_bad_rounds
            $error("msg_schedule_stream: ROUNDS must exceed 16");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_LOAD_IDX = IDX_W'(WIN_DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(ROUNDS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  win_q [WIN_DEPTH];
    logic [WORD_W-1:0]  win_d [WIN_DEPTH];
    logic               out_valid_q, out_valid_d;
    logic [WORD_W-1:0]  out_word_q, out_word_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;

    logic               adv;
    logic               shift_en;
    logic [WORD_W-1:0]  shift_word;
    logic [WORD_W-1:0]  sig0, sig1;
    logic [WORD_W-1:0]  expand_word;

    // The output register may take a new word when it is empty or being drained.
    assign adv = !out_valid_q || out_ready;

    // s0 looks at W(t-15) = win[1], s1 at W(t-2) = win[14].
    msg_sched_sigma #(
        .WORD_W (WORD_W)
    ) u_sigma (
        .s0_in  (win_q[1]),
        .s1_in  (win_q[14]),
        .s0_out (sig0),
        .s1_out (sig1)
    );

    // Wrapping sum; carries beyond WORD_W are intentionally dropped.
    assign expand_word = sig1 + win_q[9] + sig0 + win_q[0];

    // Next-state logic for the load/expand sequencer, output register and window.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        shift_en    = 1'b0;
        shift_word  = '0;

        case (state_q)
            LOAD: begin
                if (in_valid && adv) begin
                    out_word_d  = in_word;
                    out_idx_d   = cnt_q;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    shift_en    = 1'b1;
                    shift_word  = in_word;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST_LOAD_IDX) begin
                        state_d = EXPAND;
                    end
                end else if (adv) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            EXPAND: begin
                if (adv) begin
                    out_word_d  = expand_word;
                    out_idx_d   = cnt_q;
                    out_valid_d = 1'b1;
                    shift_en    = 1'b1;
                    shift_word  = expand_word;
                    out_last_d  = (cnt_q == LAST_IDX);
                    if (cnt_q == LAST_IDX) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Oldest word falls off win[0]; the newest lands in win[15].
        for (int i = 0; i < WIN_DEPTH; i++) begin
            win_d[i] = win_q[i];
        end
        if (shift_en) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[WIN_DEPTH - 1] = shift_word;
        end
    end

    // State, counter, window and output registers; reset drops any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign in_ready  = (state_q == LOAD) && adv;
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (cnt_q != '0) || (state_q == EXPAND);

endmodule

// File: tb/tb_msg_schedule_stream.sv
// Self-checking bench: SHA-256 and SHA-512 instances driven by one stream engine,
// compared against a schedule computed directly from the SHA-2 recurrence.
module tb_msg_schedule_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sel64;
    logic drv_in_valid;
    logic [63:0] drv_in_word;
    logic drv_out_ready;

    // SHA-256 instance signals
    logic        i32_valid, i32_ready, o32_ready, o32_valid, o32_last, b32;
    logic [31:0] i32_word, o32_word;
    logic [5:0]  o32_idx;
    // SHA-512 instance signals
    logic        i64_valid, i64_ready, o64_ready, o64_valid, o64_last, b64;
    logic [63:0] i64_word, o64_word;
    logic [6:0]  o64_idx;

    assign i32_valid = !sel64 && drv_in_valid;
    assign i32_word  = drv_in_word[31:0];
    assign o32_ready = sel64 ? 1'b1 : drv_out_ready;
    assign i64_valid = sel64 && drv_in_valid;
    assign i64_word  = drv_in_word;
    assign o64_ready = sel64 ? drv_out_ready : 1'b1;

    logic        mon_valid, mon_last, mon_busy, mon_in_ready;
    logic [63:0] mon_word;
    logic [31:0] mon_idx;
    assign mon_valid    = sel64 ? o64_valid : o32_valid;
    assign mon_last     = sel64 ? o64_last : o32_last;
    assign mon_busy     = sel64 ? b64 : b32;
    assign mon_in_ready = sel64 ? i64_ready : i32_ready;
    assign mon_word     = sel64 ? o64_word : {32'd0, o32_word};
    assign mon_idx      = sel64 ? {25'd0, o64_idx} : {26'd0, o32_idx};

    msg_schedule_stream #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i32_valid), .in_ready(i32_ready), .in_word(i32_word),
        .out_valid(o32_valid), .out_ready(o32_ready), .out_word(o32_word),
        .out_idx(o32_idx), .out_last(o32_last), .busy(b32)
    );

    msg_schedule_stream #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i64_valid), .in_ready(i64_ready), .in_word(i64_word),
        .out_valid(o64_valid), .out_ready(o64_ready), .out_word(o64_word),
        .out_idx(o64_idx), .out_last(o64_last), .busy(b64)
    );

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [63:0] word;
        int          idx;
        bit          last;
    } exp_t;

    logic [63:0] blk [16];
    logic [63:0] in_q [$];
    exp_t        exp_q [$];
    logic [63:0] got_word [80];
    int          n_out;
    int          b2b_hits;

    // ---------------- reference model (SHA-2 recurrence, whole-array form) ----------------
    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] ref_s0(input logic [63:0] x, input bit w64);
        if (w64) return r64(x, 1) ^ r64(x, 8) ^ (x >> 7);
        return {32'd0, r32(x[31:0], 7) ^ r32(x[31:0], 18) ^ (x[31:0] >> 3)};
    endfunction

    function automatic logic [63:0] ref_s1(input logic [63:0] x, input bit w64);
        if (w64) return r64(x, 19) ^ r64(x, 61) ^ (x >> 6);
        return {32'd0, r32(x[31:0], 17) ^ r32(x[31:0], 19) ^ (x[31:0] >> 10)};
    endfunction

    // Queue blk[] as input words and its full expected schedule.
    task automatic push_block(input bit w64);
        logic [63:0] w [80];
        int r;
        exp_t e;
        r = w64 ? 80 : 64;
        for (int t = 0; t < 16; t++) begin
            w[t] = w64 ? blk[t] : {32'd0, blk[t][31:0]};
            in_q.push_back(w[t]);
        end
        for (int t = 16; t < r; t++) begin
            w[t] = ref_s1(w[t-2], w64) + w[t-7] + ref_s0(w[t-15], w64) + w[t-16];
            if (!w64) w[t][63:32] = 32'd0;
        end
        for (int t = 0; t < r; t++) begin
            e.word = w[t];
            e.idx  = t;
            e.last = (t == r - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
    endtask

    // Streams in_q into the selected DUT and checks every output handshake.
    task automatic run_stream(input int stall_idx, input int stall_len, input bit rand_ready,
                              input int abort_idx, output bit aborted);
        int cyc, stall_cnt, r;
        bit hold, in_hs, out_hs;
        logic [63:0] pw;
        logic [31:0] pi;
        logic pl;
        exp_t e;
        cyc = 0; stall_cnt = 0; hold = 1'b0; aborted = 1'b0;
        pw = '0; pi = '0; pl = 1'b0;
        n_out = 0; b2b_hits = 0;
        r = sel64 ? 80 : 64;
        while (exp_q.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            drv_in_valid = (in_q.size() > 0);
            drv_in_word  = (in_q.size() > 0) ? in_q[0] : 64'd0;
            if (mon_valid && mon_idx == stall_idx && stall_cnt < stall_len) begin
                drv_out_ready = 1'b0;
                stall_cnt++;
            end else if (rand_ready) begin
                drv_out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                drv_out_ready = 1'b1;
            end
            #1;
            if (abort_idx >= 0 && mon_valid && mon_idx == abort_idx) begin
                aborted = 1'b1;
                break;
            end
            if (hold) begin
                n_total++;
                if (mon_valid !== 1'b1 || mon_word !== pw || mon_idx !== pi || mon_last !== pl)
                    $display("FAIL hold_stable: got v=%b w=%h i=%0d l=%b want v=1 w=%h i=%0d l=%b",
                             mon_valid, mon_word, mon_idx, mon_last, pw, pi, pl);
                else n_pass++;
            end
            in_hs  = drv_in_valid && mon_in_ready;
            out_hs = mon_valid && drv_out_ready;
            if (out_hs) begin
                e = exp_q.pop_front();
                n_total++;
                if (mon_word !== e.word || mon_idx !== e.idx || mon_last !== e.last)
                    $display("FAIL out_word: got w=%h i=%0d l=%b want w=%h i=%0d l=%b",
                             mon_word, mon_idx, mon_last, e.word, e.idx, e.last);
                else n_pass++;
                n_total++;
                if (mon_busy !== (e.idx != r - 1))
                    $display("FAIL busy_at_idx%0d: got %b want %b", e.idx, mon_busy, (e.idx != r - 1));
                else n_pass++;
                got_word[e.idx] = mon_word;
                n_out++;
                if (mon_last && in_hs) b2b_hits++;
            end
            if (in_hs) void'(in_q.pop_front());
            hold = mon_valid && !drv_out_ready;
            pw = mon_word; pi = mon_idx; pl = mon_last;
        end
        if (!aborted) begin
            n_total++;
            if (exp_q.size() != 0) $display("FAIL stream_timeout: got %0d words left want 0", exp_q.size());
            else n_pass++;
            @(negedge clk);
            drv_in_valid = 1'b0;
            drv_out_ready = 1'b1;
            #1;
            n_total++;
            if (mon_valid !== 1'b0 || mon_busy !== 1'b0)
                $display("FAIL idle_after_block: got v=%b busy=%b want v=0 busy=0", mon_valid, mon_busy);
            else n_pass++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_total++;
        if (o32_valid !== 1'b0 || o32_word !== 32'd0 || o32_idx !== 6'd0 || o32_last !== 1'b0 || b32 !== 1'b0)
            $display("FAIL reset32: got v=%b w=%h i=%0d l=%b b=%b want all 0", o32_valid, o32_word, o32_idx, o32_last, b32);
        else n_pass++;
        n_total++;
        if (o64_valid !== 1'b0 || o64_word !== 64'd0 || o64_idx !== 7'd0 || o64_last !== 1'b0 || b64 !== 1'b0)
            $display("FAIL reset64: got v=%b w=%h i=%0d l=%b b=%b want all 0", o64_valid, o64_word, o64_idx, o64_last, b64);
        else n_pass++;
        n_total++;
        if (i32_ready !== 1'b1 || i64_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b/%b want 1/1", i32_ready, i64_ready);
        else n_pass++;
    endtask

    task automatic test_abc256();
        bit ab;
        sel64 = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = 64'd0;
        blk[0] = 64'h61626380; blk[15] = 64'h18;
        push_block(1'b0);
        run_stream(-1, 0, 1'b0, -1, ab);
        n_total++;
        if (n_out != 64) $display("FAIL abc256_count: got %0d want 64", n_out); else n_pass++;
        n_total++;
        if (got_word[16] !== 64'h61626380) $display("FAIL abc256_w16: got %h want 61626380", got_word[16]); else n_pass++;
        n_total++;
        if (got_word[17] !== 64'h000F0000) $display("FAIL abc256_w17: got %h want 000f0000", got_word[17]); else n_pass++;
        $display("abc256: %0d words", n_out);
    endtask

    task automatic test_zero();
        bit ab;
        sel64 = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = 64'd0;
        push_block(1'b0);
        run_stream(-1, 0, 1'b0, -1, ab);
        n_total++;
        if (n_out != 64) $display("FAIL zero_count: got %0d want 64", n_out); else n_pass++;
        $display("zero block: %0d words", n_out);
    endtask

    task automatic test_backpressure();
        bit ab;
        sel64 = 1'b0;
        rand_block();
        push_block(1'b0);
        run_stream(20, 5, 1'b0, -1, ab);
        n_total++;
        if (n_out != 64) $display("FAIL bp_count: got %0d want 64", n_out); else n_pass++;
        $display("backpressure at 20: %0d words", n_out);
    endtask

    task automatic test_back_to_back();
        bit ab;
        sel64 = 1'b0;
        rand_block(); push_block(1'b0);
        rand_block(); push_block(1'b0);
        run_stream(-1, 0, 1'b0, -1, ab);
        n_total++;
        if (n_out != 128) $display("FAIL b2b_count: got %0d want 128", n_out); else n_pass++;
        n_total++;
        if (b2b_hits != 1) $display("FAIL b2b_zero_bubble: got %0d want 1", b2b_hits); else n_pass++;
        $display("back_to_back: %0d words, overlap %0d", n_out, b2b_hits);
    endtask

    task automatic test_random();
        bit ab;
        for (int k = 0; k < 3; k++) begin
            sel64 = (k == 2);
            rand_block();
            push_block(sel64);
            run_stream(-1, 0, 1'b1, -1, ab);
            n_total++;
            if (n_out != (sel64 ? 80 : 64)) $display("FAIL rand_count: got %0d want %0d", n_out, sel64 ? 80 : 64);
            else n_pass++;
            $display("random block %0d (w64=%0d): %0d words", k, sel64, n_out);
        end
        sel64 = 1'b0;
    endtask

    task automatic test_sha512();
        bit ab;
        sel64 = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = 64'd0;
        blk[0] = 64'h6162638000000000; blk[15] = 64'h18;
        push_block(1'b1);
        run_stream(-1, 0, 1'b0, -1, ab);
        n_total++;
        if (n_out != 80) $display("FAIL abc512_count: got %0d want 80", n_out); else n_pass++;
        n_total++;
        if (got_word[16] !== 64'h6162638000000000) $display("FAIL abc512_w16: got %h want 6162638000000000", got_word[16]); else n_pass++;
        n_total++;
        if (got_word[17] !== 64'h00030000000000C0) $display("FAIL abc512_w17: got %h want 00030000000000c0", got_word[17]); else n_pass++;
        $display("abc512: %0d words", n_out);
        sel64 = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ab;
        sel64 = 1'b0;
        rand_block();
        push_block(1'b0);
        run_stream(-1, 0, 1'b0, 30, ab);
        n_total++;
        if (!ab) $display("FAIL midreset_reach30: got %b want 1", ab); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (o32_valid !== 1'b0 || o32_word !== 32'd0 || o32_idx !== 6'd0 || o32_last !== 1'b0 || b32 !== 1'b0)
            $display("FAIL midreset_outputs: got v=%b w=%h i=%0d l=%b b=%b want all 0", o32_valid, o32_word, o32_idx, o32_last, b32);
        else n_pass++;
        in_q.delete();
        exp_q.delete();
        drv_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rand_block();
        push_block(1'b0);
        run_stream(-1, 0, 1'b0, -1, ab);
        n_total++;
        if (n_out != 64) $display("FAIL midreset_next_count: got %0d want 64", n_out); else n_pass++;
        $display("reset mid-block, next block: %0d words", n_out);
    endtask

    initial begin
        rst_n = 1'b1;
        sel64 = 1'b0;
        drv_in_valid = 1'b0;
        drv_in_word = 64'd0;
        drv_out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_abc256();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_sha512();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
